// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared defaults, derived sizes and window slice indexing for the convolver
package conv_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int KERNEL_DEF = 3;
    localparam int IMG_W_DEF  = 8;
    localparam int IMG_H_DEF  = 8;

    localparam int INPUTS   = KERNEL_DEF * KERNEL_DEF;
    localparam int COL_BITS = $clog2(IMG_W_DEF);
    localparam int ROW_BITS = $clog2(IMG_H_DEF);

    // Slice index of window element (r,c); r=0 is the oldest row, c=0 the leftmost column.
    function automatic int idx(input int r, input int c, input int kernel);
        return r * kernel + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - one image row of storage, read-before-write at a shared column address
module conv_line_buffer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     wr_data,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The read returns the word stored before this cycle's write lands at the edge.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to packed KERNEL x KERNEL sliding windows
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int KERNEL = KERNEL_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH*KERNEL*KERNEL-1:0] win_data,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic                        frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LB = KERNEL - 1;

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [WIDTH-1:0] win     [KERNEL][KERNEL];
    logic [WIDTH-1:0] new_col [KERNEL];
    logic [WIDTH-1:0] lb_rd   [LB];
    logic [WIDTH-1:0] lb_wr   [LB];
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             emit;

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready && !clear;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign emit     = (row >= RW'(KERNEL - 1)) && (col >= CW'(KERNEL - 1));

    // Buffer LB-1 holds the previous row; each accept pushes every stored row up one buffer.
    for (genvar j = 0; j < LB; j++) begin : g_lb
        if (j == LB - 1) begin : g_bottom
            assign lb_wr[j] = in_data;
        end else begin : g_upper
            assign lb_wr[j] = lb_rd[j+1];
        end

        conv_line_buffer #(
            .WIDTH    (WIDTH),
            .DEPTH    (IMG_W),
            .ADDR_BITS(CW)
        ) u_line_buffer (
            .clk    (clk),
            .wr_en  (accept),
            .addr   (col),
            .wr_data(lb_wr[j]),
            .rd_data(lb_rd[j])
        );

        assign new_col[j] = lb_rd[j];
    end

    assign new_col[KERNEL-1] = in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][KERNEL-1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && col_last && row_last;
            if (accept) begin
                win_valid <= emit;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    // The window registers only move on accept, so the bus is stable under backpressure.
    for (genvar r = 0; r < KERNEL; r++) begin : g_pack_row
        for (genvar c = 0; c < KERNEL; c++) begin : g_pack_col
            assign win_data[idx(r, c, KERNEL)*WIDTH +: WIDTH] = win[r][c];
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen
module tb_conv_window_gen;

    localparam int WIDTH  = 8;
    localparam int KERNEL = 3;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int TAPS   = KERNEL * KERNEL;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef struct packed {
        logic [WIDTH-1:0]      pix;
        logic                  ev;
        logic                  efd;
        logic [WIDTH*TAPS-1:0] win;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  clear;
    logic [WIDTH-1:0]      in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH*TAPS-1:0] win_data;
    logic                  win_valid;
    logic                  win_ready;
    logic                  frame_done;

    int checks = 0;
    int errors = 0;
    int n_win  = 0;
    int n_fd   = 0;
    int fd_base;

    int                    m_n;
    bit                    m_valid;
    bit                    m_fd;
    logic [WIDTH*TAPS-1:0] m_win;
    logic [WIDTH-1:0]      img [IMG_H][IMG_W];
    vec_t                  tbl [NPIX];

    conv_window_gen #(
        .WIDTH (WIDTH),
        .KERNEL(KERNEL),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [WIDTH*TAPS-1:0] act, input logic [WIDTH*TAPS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Window whose top-left pixel value is base, for frames valued base+row*IMG_W+col.
    function automatic logic [WIDTH*TAPS-1:0] mkwin(input int base);
        logic [WIDTH*TAPS-1:0] w;
        w = '0;
        for (int i = 0; i < KERNEL; i++) begin
            for (int j = 0; j < KERNEL; j++) begin
                w[(i*KERNEL+j)*WIDTH +: WIDTH] = WIDTH'(base + i*IMG_W + j);
            end
        end
        return w;
    endfunction

    // Called just after a falling edge: drive, check the current state against the
    // model, update the model for what the next rising edge commits, then move on.
    task automatic tick(input bit v, input logic [WIDTH-1:0] d, input bit rdy, input bit clr);
        bit acc;
        int r;
        int c;
        in_valid  = v;
        in_data   = d;
        win_ready = rdy;
        clear     = clr;
        #1;
        chk1("in_ready", in_ready, !m_valid || rdy);
        chk1("win_valid", win_valid, m_valid);
        chk1("frame_done", frame_done, m_fd);
        if (m_valid) chkw("win_data", win_data, m_win);
        if (win_valid && rdy) n_win++;
        if (frame_done) n_fd++;
        acc  = v && (!m_valid || rdy) && !clr;
        m_fd = 0;
        if (clr) begin
            m_n     = 0;
            m_valid = 0;
        end else if (acc) begin
            r = m_n / IMG_W;
            c = m_n % IMG_W;
            img[r][c] = d;
            m_valid = (r >= KERNEL-1) && (c >= KERNEL-1);
            if (m_valid) begin
                for (int i = 0; i < KERNEL; i++) begin
                    for (int j = 0; j < KERNEL; j++) begin
                        m_win[(i*KERNEL+j)*WIDTH +: WIDTH] = img[r-KERNEL+1+i][c-KERNEL+1+j];
                    end
                end
            end
            m_fd = (m_n == NPIX-1);
            m_n  = (m_n + 1) % NPIX;
        end else if (rdy) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        win_ready = 1'b1;
        clear     = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            chk1("rst_win_valid", win_valid, 1'b0);
            chk1("rst_frame_done", frame_done, 1'b0);
            chkw("rst_win_data", win_data, '0);
            @(negedge clk);
        end
        m_n     = 0;
        m_valid = 0;
        m_fd    = 0;
        rst_n   = 1'b1;
    endtask

    initial begin
        m_win = '0;
        @(negedge clk);
        do_reset(2);
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        for (int k = 0; k < NPIX; k++) begin
            tbl[k].pix = WIDTH'(k);
            tbl[k].ev  = (k == 10) || (k == 11) || (k == 14) || (k == 15);
            tbl[k].efd = (k == NPIX-1);
            tbl[k].win = '0;
        end
        tbl[10].win = mkwin(0);
        tbl[11].win = mkwin(1);
        tbl[14].win = mkwin(4);
        tbl[15].win = mkwin(5);

        n_win   = 0;
        fd_base = n_fd;
        for (int k = 0; k < NPIX; k++) begin
            tick(1'b1, tbl[k].pix, 1'b1, 1'b0);
            chk1($sformatf("tbl%0d_valid", k), win_valid, tbl[k].ev);
            chk1($sformatf("tbl%0d_fd", k), frame_done, tbl[k].efd);
            if (tbl[k].ev) chkw($sformatf("tbl%0d_win", k), win_data, tbl[k].win);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        chki("basic_windows", n_win, 4);
        chki("basic_frame_done", n_fd - fd_base, 1);

        n_win = 0;
        for (int k = 0; k <= 10; k++) tick(1'b1, WIDTH'(k), 1'b1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            tick(1'b1, WIDTH'(11), 1'b0, 1'b0);
            chk1("bp_in_ready", in_ready, 1'b0);
            chkw("bp_hold", win_data, mkwin(0));
        end
        for (int k = 11; k < NPIX; k++) tick(1'b1, WIDTH'(k), 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        chki("bp_windows", n_win, 4);

        for (int k = 0; k <= 9; k++) tick(1'b1, WIDTH'(k), 1'b1, 1'b0);
        do_reset(3);
        for (int k = 0; k < NPIX; k++) begin
            tick(1'b1, WIDTH'(100 + k), 1'b1, 1'b0);
            if (k == 10) begin
                chk1("rst_first_valid", win_valid, 1'b1);
                chkw("rst_first_win", win_data, mkwin(100));
            end
        end
        tick(1'b0, '0, 1'b1, 1'b0);

        n_win = 0;
        for (int k = 0; k < NPIX; k++) tick(1'b1, WIDTH'(k), 1'b1, 1'b0);
        for (int k = 0; k < NPIX; k++) begin
            tick(1'b1, WIDTH'(200 + k), 1'b1, 1'b0);
            if (k == 10) begin
                for (int i = 0; i < TAPS; i++) begin
                    chk1($sformatf("b2b_fresh%0d", i), win_data[i*WIDTH +: WIDTH] >= WIDTH'(200), 1'b1);
                end
            end
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        chki("b2b_windows", n_win, 8);

        for (int k = 0; k <= 5; k++) tick(1'b1, WIDTH'(k), 1'b1, 1'b0);
        tick(1'b1, WIDTH'(6), 1'b1, 1'b1);
        n_win = 0;
        for (int k = 0; k < NPIX; k++) tick(1'b1, WIDTH'(50 + k), 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        chki("clear_windows", n_win, 4);

        for (int n = 0; n < 800; n++) begin
            tick($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) == 0);
        end
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
